if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the fetch PC,
//  issues requests to instruction memory over a req/ack handshake and buffers returned words in a
//  small prefetch FIFO. Presents {pc+4, instr} to IF/ID and honours the same hazard (stall) and
//  branch-redirect (flush) controls. Inserts a NOP bubble while no instruction is available.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset; bits [1:0] must be 0
//  DEPTH     2              prefetch FIFO entries; power of 2, >= 2
// PORTS
//  clk_i          in   1   clock, all state on posedge
//  rst_i          in   1   reset, synchronous, active-high
//  hazard_i       in   1   stall from hazard unit: hold FIFO head, no pop
//  branch_i       in   1   redirect: flush FIFO, refetch from branch_addr_i
//  branch_addr_i  in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o     out  1   instruction-memory request valid
//  imem_addr_o    out  32  request address; stable while imem_req_o=1 and no ack
//  imem_ack_i     in   1   response valid; may assert in the same cycle as req (zero-wait)
//  imem_data_i    in   32  instruction word, valid when imem_ack_i=1
//  valid_o        out  1   FIFO head valid
//  pc_o           out  32  head fetch address + 4; 0 when valid_o=0
//  instr_o        out  32  head instruction; 32'h0 (NOP) when valid_o=0
// BEHAVIOUR
//  - Reset: state IDLE, fetch_pc=RESET_PC, FIFO empty; imem_req_o=0, valid_o=0, pc_o=0, instr_o=0.
//  - FSM: IDLE -> RUN unconditionally (one cycle). RUN -> DRAIN when branch_i=1 while a request
//    is outstanding and imem_ack_i=0 that cycle. DRAIN -> RUN on imem_ack_i=1. rst_i overrides all.
//  - At most one outstanding request. RUN: imem_req_o = (count < DEPTH); imem_addr_o = fetch_pc.
//    DRAIN: imem_req_o=1, imem_addr_o = stale address (held until ack).
//  - Ack in RUN without branch: push {fetch_pc+4, imem_data_i}; fetch_pc += 4 (mod 2^32).
//  - Ack in DRAIN, or ack in the same cycle as branch_i: data discarded, no push.
//  - Pop when valid_o & ~hazard_i & ~branch_i. Push and pop in one cycle: count unchanged.
//  - branch_i (priority over hazard_i): FIFO emptied next cycle; fetch_pc <= {branch_addr_i[31:2],2'b00};
//    next req (RUN) uses the new address. branch_i in DRAIN: retarget fetch_pc, stay in DRAIN.
//  - Latency: ack at edge N -> valid_o=1 with that word from cycle N+1 (registered FIFO output).
//    Zero-wait memory sustains 1 instr/cycle with DEPTH=2; no comb path hazard_i -> imem_req_o.
//  - FIFO full (count=DEPTH): imem_req_o=0 in RUN; a pending request never times out.
//  - valid_o=0 forces pc_o=0, instr_o=0 so IF/ID latches a bubble.
// STRUCTURE
//  - Shared package: state encodings IDLE/RUN/DRAIN, NOP_INSTR=32'h0, INSTR_W=32, ADDR_W=32.
//  - Sub-module fetch_fifo: DEPTH x 64-bit {pc4,instr}, push/pop/flush, count, registered head.
//  - Top: FSM, fetch_pc register, request/discard logic, output NOP mux.
// TESTING
//  1 rst_i=1 for 3 cycles -> imem_req_o=0, valid_o=0, pc_o=0, instr_o=0; after release 1 cycle
//    IDLE, then req addr 0x0.
//  2 Zero-wait mem, mem[a]=0xA000_0000|a, no stalls -> valid_o=1 every cycle from cycle 2,
//    pc_o=4,8,12,..., instr_o=0xA000_0000,0xA000_0004,...
//  3 Zero-wait, hazard_i=1 for 3 cycles -> FIFO fills to 2, imem_req_o=0, outputs frozen;
//    on release stream resumes with no lost or duplicated word.
//  4 3-cycle-latency mem, branch_i with target 0x100 while req 0x8 outstanding -> addr holds
//    0x8 until ack, word dropped, next req 0x100, first valid pc_o=0x104.
//  5 branch_i=1, hazard_i=1 and imem_ack_i=1 in one cycle -> next cycle valid_o=0, instr_o=0,
//    acked word never appears, next req = target.
//  6 RESET_PC=0xFFFF_FFF8 -> req addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_o FFFF_FFFC, 0, 4.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc+4, instr} entries; head is read straight from storage registers.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request, prefetch FIFO, bubble mux.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t       state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  drain_addr;
  logic [ADDR_W-1:0]  target;
  logic [CW-1:0]      count;
  logic               accept;
  logic               push;
  logic               pop;
  logic               head_valid;
  fetch_entry_t       head;
  fetch_entry_t       wdata;

  assign target = branch_addr_i & ~32'h3;

  // Request depends only on registered state, so hazard_i never reaches imem_req_o.
  assign imem_req_o  = (state == DRAIN) || ((state == RUN) && (count < CW'(DEPTH)));
  assign imem_addr_o = (state == DRAIN) ? drain_addr : fetch_pc;

  assign accept = imem_req_o && imem_ack_i;
  assign push   = accept && (state == RUN) && !branch_i;
  assign pop    = head_valid && !hazard_i && !branch_i;

  assign wdata.pc4   = fetch_pc + 32'd4;
  assign wdata.instr = imem_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          if (branch_i) fetch_pc <= target;
        end
        RUN: begin
          if (branch_i) begin
            fetch_pc <= target;
            // A request still in flight must complete at its old address before refetching.
            if (imem_req_o && !imem_ack_i) begin
              state      <= DRAIN;
              drain_addr <= fetch_pc;
            end
          end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (imem_ack_i) state <= RUN;
          if (branch_i) fetch_pc <= target;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .pop        (pop),
    .flush      (branch_i),
    .wdata      (wdata),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign valid_o = head_valid;
  assign pc_o    = head_valid ? head.pc4   : '0;
  assign instr_o = head_valid ? head.instr : NOP_INSTR;

endmodule
